// File: rtl/snk68_bus_pkg.sv
// Shared types and per-PCB region tables for the SNK 68K bus region decoder.
// Table entries use the same base/mask/wait/dir layout as the runtime region ports.
package snk68_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_WAIT,
        ST_ACK,
        ST_MISS,
        ST_BERR
    } state_e;

    typedef enum logic [1:0] {
        PCB_RUNTIME,
        PCB_A7007_A8007,
        PCB_A7008,
        PCB_A7008_SS
    } pcb_e;

    localparam int TBL_AW     = 24;
    localparam int TBL_WAIT_W = 4;
    localparam int DIR_W      = 2;
    localparam int CNT_W      = 16;

    localparam logic [1:0] DIR_RD = 2'b01;
    localparam logic [1:0] DIR_WR = 2'b10;
    localparam logic [1:0] DIR_RW = 2'b11;

    typedef struct packed {
        logic [TBL_AW-1:0]     base;
        logic [TBL_AW-1:0]     mask;
        logic [TBL_WAIT_W-1:0] wait_cnt;
        logic [DIR_W-1:0]      dir;
    } region_t;

    function automatic region_t mk(logic [23:0] b, logic [23:0] m, logic [3:0] w, logic [1:0] d);
        return '{base: b, mask: m, wait_cnt: w, dir: d};
    endfunction

    // Unlisted slots keep dir=0, so they can never hit.
    function automatic region_t pcb_region(pcb_e pcb, int idx);
        region_t r = '0;
        case (pcb)
            PCB_A7007_A8007: case (idx)
                0: r = mk(24'h000000, 24'hFC0000, 4'd0, DIR_RD);
                1: r = mk(24'h040000, 24'hFFC000, 4'd0, DIR_RW);
                2: r = mk(24'h080000, 24'hFFF000, 4'd1, DIR_RD);
                3: r = mk(24'h080000, 24'hFFF000, 4'd1, DIR_WR);
                4: r = mk(24'h0F0000, 24'hFFF000, 4'd1, DIR_RD);
                5: r = mk(24'h100000, 24'hFFF000, 4'd1, DIR_RW);
                6: r = mk(24'h200000, 24'hFFC000, 4'd1, DIR_RW);
                7: r = mk(24'h400000, 24'hFFF000, 4'd0, DIR_RW);
                default: ;
            endcase
            PCB_A7008: case (idx)
                0: r = mk(24'h000000, 24'hFC0000, 4'd0, DIR_RD);
                1: r = mk(24'h040000, 24'hFFC000, 4'd0, DIR_RW);
                2: r = mk(24'h080000, 24'hFFF000, 4'd1, DIR_RD);
                3: r = mk(24'h080000, 24'hFFF000, 4'd1, DIR_WR);
                4: r = mk(24'h0C0000, 24'hFFF000, 4'd1, DIR_RD);
                5: r = mk(24'h100000, 24'hFFF800, 4'd1, DIR_RW);
                6: r = mk(24'h200000, 24'hFF8000, 4'd2, DIR_RW);
                7: r = mk(24'h400000, 24'hFFF000, 4'd0, DIR_RW);
                default: ;
            endcase
            PCB_A7008_SS: case (idx)
                0: r = mk(24'h000000, 24'hFC0000, 4'd0, DIR_RD);
                1: r = mk(24'h040000, 24'hFFC000, 4'd0, DIR_RW);
                2: r = mk(24'h080000, 24'hFFF000, 4'd1, DIR_RD);
                3: r = mk(24'h080000, 24'hFFF000, 4'd1, DIR_WR);
                4: r = mk(24'h0C0000, 24'hFFF000, 4'd1, DIR_RD);
                5: r = mk(24'h200000, 24'hFF8000, 4'd2, DIR_RW);
                6: r = mk(24'h400000, 24'hFFF000, 4'd0, DIR_RW);
                default: ;
            endcase
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/m68k_region_decoder_prio_match.sv
// Combinational region match: per-region hit vector reduced to the lowest hitting index.
module region_prio_match
    import snk68_bus_pkg::*;
#(
    parameter int NREG = 16,
    parameter int AW   = 24,
    parameter int IW   = $clog2(NREG)
) (
    input  logic [AW-1:0]      lat_a,
    input  logic               lat_rw,
    input  logic [NREG*AW-1:0] base,
    input  logic [NREG*AW-1:0] mask,
    input  logic [NREG*2-1:0]  dir,
    output logic               hit,
    output logic [IW-1:0]      idx
);

    always_comb begin
        // NOTE: outputs get defaults before the loop so no path leaves them unassigned (no latch).
        hit = 1'b0;
        idx = '0;
        // Scanning downwards lets the lowest matching index be the last one written.
        for (int i = NREG - 1; i >= 0; i--) begin
            if ((((lat_a ^ base[i*AW +: AW]) & mask[i*AW +: AW]) == '0) &&
                (lat_rw ? dir[2*i] : dir[2*i+1])) begin
                hit = 1'b1;
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/m68k_region_decoder.sv
// Registered 68K chip-select decoder: base/mask regions, per-region DTACK wait states,
// and a /BERR timeout for unmapped accesses.
module m68k_region_decoder
    import snk68_bus_pkg::*;
#(
    parameter int   NREG    = 16,
    parameter int   AW      = 24,
    parameter int   WAIT_W  = 4,
    parameter int   TIMEOUT = 64,
    parameter pcb_e PCB     = PCB_RUNTIME
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [AW-1:0]              m68k_a,
    input  logic                       m68k_as_n,
    input  logic                       m68k_rw,
    input  logic [NREG*AW-1:0]         region_base,
    input  logic [NREG*AW-1:0]         region_mask,
    input  logic [NREG*WAIT_W-1:0]     region_wait,
    input  logic [NREG*2-1:0]          region_dir,
    output logic [NREG-1:0]            cs,
    output logic [$clog2(NREG)-1:0]    region_idx,
    output logic                       hit,
    output logic                       dtack_n,
    output logic                       berr_n,
    output logic                       busy
);

    localparam int IW = $clog2(NREG);

    logic [NREG*AW-1:0]     tbl_base, tbl_mask;
    logic [NREG*WAIT_W-1:0] tbl_wait;
    logic [NREG*2-1:0]      tbl_dir;

    if (PCB == PCB_RUNTIME) begin : g_runtime
        assign tbl_base = region_base;
        assign tbl_mask = region_mask;
        assign tbl_wait = region_wait;
        assign tbl_dir  = region_dir;
    end else begin : g_pcb
        for (genvar i = 0; i < NREG; i++) begin : g_ent
            localparam region_t R = pcb_region(PCB, i);
            assign tbl_base[i*AW +: AW]         = AW'(R.base);
            assign tbl_mask[i*AW +: AW]         = AW'(R.mask);
            assign tbl_wait[i*WAIT_W +: WAIT_W] = WAIT_W'(R.wait_cnt);
            assign tbl_dir[i*2 +: 2]            = R.dir;
        end
    end

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NREG-1:0]   cs_q, cs_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              hit_q, hit_d;
    logic              dtack_n_q, dtack_n_d;
    logic              berr_n_q, berr_n_d;
    logic [AW-1:0]     lat_a_q, lat_a_d;
    logic              lat_rw_q, lat_rw_d;
    logic              in_as_n_q, in_as_n_d;
    logic [AW-1:0]     in_a_q, in_a_d;
    logic              in_rw_q, in_rw_d;

    logic              m_hit;
    logic [IW-1:0]     m_idx;
    logic [WAIT_W-1:0] m_wait;
    logic              go_idle;

    region_prio_match #(.NREG(NREG), .AW(AW), .IW(IW)) u_match (
        .lat_a  (lat_a_q),
        .lat_rw (lat_rw_q),
        .base   (tbl_base),
        .mask   (tbl_mask),
        .dir    (tbl_dir),
        .hit    (m_hit),
        .idx    (m_idx)
    );

    assign m_wait = tbl_wait[m_idx*WAIT_W +: WAIT_W];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cs_d      = cs_q;
        idx_d     = idx_q;
        hit_d     = hit_q;
        dtack_n_d = dtack_n_q;
        berr_n_d  = berr_n_q;
        lat_a_d   = lat_a_q;
        lat_rw_d  = lat_rw_q;
        in_as_n_d = m68k_as_n;
        in_a_d    = m68k_a;
        in_rw_d   = m68k_rw;
        go_idle   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Start from the registered strobe; release/abort below use the live one.
                if (!in_as_n_q) begin
                    lat_a_d  = in_a_q;
                    lat_rw_d = in_rw_q;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (m68k_as_n) begin
                    go_idle = 1'b1;
                end else if (m_hit) begin
                    cs_d  = NREG'(1) << m_idx;
                    idx_d = m_idx;
                    hit_d = 1'b1;
                    cnt_d = CNT_W'(m_wait);
                    if (m_wait == '0) begin
                        state_d   = ST_ACK;
                        dtack_n_d = 1'b0;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    cs_d    = '0;
                    hit_d   = 1'b0;
                    cnt_d   = CNT_W'(TIMEOUT - 1);
                    state_d = ST_MISS;
                end
            end
            ST_WAIT: begin
                if (m68k_as_n) begin
                    go_idle = 1'b1;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d   = ST_ACK;
                    dtack_n_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_MISS: begin
                if (m68k_as_n) begin
                    go_idle = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d  = ST_BERR;
                    berr_n_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ACK, ST_BERR: begin
                if (m68k_as_n) go_idle = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (go_idle) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            cs_d      = '0;
            idx_d     = '0;
            hit_d     = 1'b0;
            dtack_n_d = 1'b1;
            berr_n_d  = 1'b1;
        end
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            cs_q      <= '0;
            idx_q     <= '0;
            hit_q     <= 1'b0;
            dtack_n_q <= 1'b1;
            berr_n_q  <= 1'b1;
            lat_a_q   <= '0;
            lat_rw_q  <= 1'b1;
            in_as_n_q <= 1'b1;
            in_a_q    <= '0;
            in_rw_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cs_q      <= cs_d;
            idx_q     <= idx_d;
            hit_q     <= hit_d;
            dtack_n_q <= dtack_n_d;
            berr_n_q  <= berr_n_d;
            lat_a_q   <= lat_a_d;
            lat_rw_q  <= lat_rw_d;
            in_as_n_q <= in_as_n_d;
            in_a_q    <= in_a_d;
            in_rw_q   <= in_rw_d;
        end
    end

    assign cs         = cs_q;
    assign region_idx = idx_q;
    assign hit        = hit_q;
    assign dtack_n    = dtack_n_q;
    assign berr_n     = berr_n_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_m68k_region_decoder.sv
// Randomised bench for m68k_region_decoder against a per-access timing model.
module tb_m68k_region_decoder;

    localparam int NREG    = 16;
    localparam int AW      = 24;
    localparam int WAIT_W  = 4;
    localparam int TIMEOUT = 64;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [AW-1:0]           m68k_a;
    logic                    m68k_as_n;
    logic                    m68k_rw;
    logic [NREG*AW-1:0]      region_base;
    logic [NREG*AW-1:0]      region_mask;
    logic [NREG*WAIT_W-1:0]  region_wait;
    logic [NREG*2-1:0]       region_dir;
    logic [NREG-1:0]         cs;
    logic [$clog2(NREG)-1:0] region_idx;
    logic                    hit;
    logic                    dtack_n;
    logic                    berr_n;
    logic                    busy;

    logic [AW-1:0]     cfg_base [NREG];
    logic [AW-1:0]     cfg_mask [NREG];
    logic [WAIT_W-1:0] cfg_wait [NREG];
    logic [1:0]        cfg_dir  [NREG];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NREG; g++) begin : g_cfg
        assign region_base[g*AW +: AW]         = cfg_base[g];
        assign region_mask[g*AW +: AW]         = cfg_mask[g];
        assign region_wait[g*WAIT_W +: WAIT_W] = cfg_wait[g];
        assign region_dir[g*2 +: 2]            = cfg_dir[g];
    end

    m68k_region_decoder #(
        .NREG(NREG), .AW(AW), .WAIT_W(WAIT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .m68k_a      (m68k_a),
        .m68k_as_n   (m68k_as_n),
        .m68k_rw     (m68k_rw),
        .region_base (region_base),
        .region_mask (region_mask),
        .region_wait (region_wait),
        .region_dir  (region_dir),
        .cs          (cs),
        .region_idx  (region_idx),
        .hit         (hit),
        .dtack_n     (dtack_n),
        .berr_n      (berr_n),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=0x%0h expected=0x%0h", tag, $time, got, exp);
        end
    endtask

    // First region (lowest index) whose masked base equals the address and whose direction allows the access.
    function automatic int model_region(logic [AW-1:0] a, logic rw);
        for (int i = 0; i < NREG; i++) begin
            if (((a & cfg_mask[i]) == (cfg_base[i] & cfg_mask[i])) &&
                (rw ? cfg_dir[i][0] : cfg_dir[i][1]))
                return i;
        end
        return -1;
    endfunction

    function automatic int resp_edge(int ridx);
        return (ridx >= 0) ? 2 + int'(cfg_wait[ridx]) : 2 + TIMEOUT;
    endfunction

    task automatic clear_cfg();
        for (int i = 0; i < NREG; i++) begin
            cfg_base[i] = '0; cfg_mask[i] = '0; cfg_wait[i] = '0; cfg_dir[i] = 2'b00;
        end
    endtask

    task automatic random_cfg();
        logic [AW-1:0] pats [5];
        pats[0] = 24'hFC0000; pats[1] = 24'hFF0000; pats[2] = 24'hFFF000;
        pats[3] = 24'hF00000; pats[4] = 24'hFFC000;
        for (int i = 0; i < NREG; i++) begin
            cfg_mask[i] = pats[$urandom_range(0, 4)];
            cfg_base[i] = AW'($urandom) & cfg_mask[i];
            cfg_wait[i] = WAIT_W'($urandom_range(0, 15));
            cfg_dir[i]  = 2'($urandom_range(0, 3));
        end
        if ($urandom_range(0, 1) == 1) begin
            cfg_mask[NREG-1] = '0;
            cfg_dir[NREG-1]  = 2'b11;
        end
    endtask

    // Edge T samples AS low; AS is next sampled high at edge T+rel. Checks every edge T+1..T+rel.
    task automatic run_access(input logic [AW-1:0] a, input logic rw, input int rel, input bit scramble);
        int  ridx   = model_region(a, rw);
        int  resp_k = resp_edge(ridx);
        bit  active;
        @(negedge clk);
        m68k_a    = a;
        m68k_rw   = rw;
        m68k_as_n = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= rel; k++) begin
            @(negedge clk);
            if (k == rel) m68k_as_n = 1'b1;
            if (scramble && k == 3) begin
                random_cfg();
                m68k_a  = AW'($urandom);
                m68k_rw = ~rw;
            end
            @(posedge clk);
            #1;
            active = (k >= 2) && (k < rel);
            check($sformatf("cs@T+%0d", k), 32'(cs),
                  (active && ridx >= 0) ? 32'(1) << ridx : 32'd0);
            check($sformatf("hit@T+%0d", k), 32'(hit), 32'(active && ridx >= 0));
            if (active && ridx >= 0)
                check($sformatf("region_idx@T+%0d", k), 32'(region_idx), 32'(ridx));
            check($sformatf("busy@T+%0d", k), 32'(busy), 32'(k < rel));
            check($sformatf("dtack_n@T+%0d", k), 32'(dtack_n),
                  32'(!(ridx >= 0 && resp_k < rel && k >= resp_k && k < rel)));
            check($sformatf("berr_n@T+%0d", k), 32'(berr_n),
                  32'(!(ridx < 0 && resp_k < rel && k >= resp_k && k < rel)));
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_cs"},      32'(cs),      32'd0);
        check({tag, "_hit"},     32'(hit),     32'd0);
        check({tag, "_dtack_n"}, 32'(dtack_n), 32'd1);
        check({tag, "_berr_n"},  32'(berr_n),  32'd1);
        check({tag, "_busy"},    32'(busy),    32'd0);
    endtask

    initial begin
        int ridx, rk, rel, j;
        logic [AW-1:0] a;
        logic rw;

        reset     = 1'b1;
        m68k_as_n = 1'b1;
        m68k_a    = '0;
        m68k_rw   = 1'b1;
        clear_cfg();
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        check("reset_region_idx", 32'(region_idx), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        cfg_base[0] = 24'h000000; cfg_mask[0] = 24'hFC0000; cfg_wait[0] = 4'd0; cfg_dir[0] = 2'b11;
        cfg_base[1] = 24'h080000; cfg_mask[1] = 24'hFFF000; cfg_wait[1] = 4'd1; cfg_dir[1] = 2'b01;
        cfg_base[2] = 24'h400000; cfg_mask[2] = 24'hFFF000; cfg_wait[2] = 4'd3; cfg_dir[2] = 2'b11;
        cfg_base[3] = 24'h080000; cfg_mask[3] = 24'hFFF000; cfg_wait[3] = 4'd2; cfg_dir[3] = 2'b10;
        cfg_base[4] = 24'h600000; cfg_mask[4] = 24'hFFF000; cfg_wait[4] = 4'd7; cfg_dir[4] = 2'b11;

        run_access(24'h01234A, 1'b1, 3, 1'b0);
        run_access(24'h400010, 1'b0, 7, 1'b0);
        run_access(24'h080000, 1'b0, 5, 1'b0);
        run_access(24'h080000, 1'b1, 4, 1'b0);
        run_access(24'h500000, 1'b1, 2 + TIMEOUT + 2, 1'b0);
        run_access(24'h600004, 1'b1, 4, 1'b0);

        @(negedge clk);
        m68k_a = 24'h000100; m68k_rw = 1'b1; m68k_as_n = 1'b0;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check("pre_reset_dtack_n", 32'(dtack_n), 32'd0);
        @(negedge clk);
        reset = 1'b1; m68k_as_n = 1'b1;
        @(posedge clk);
        #1;
        check_idle("ack_reset");
        @(negedge clk);
        reset = 1'b0;
        run_access(24'h400020, 1'b1, 6, 1'b0);

        for (int n = 0; n < 15; n++) begin
            random_cfg();
            for (int m = 0; m < 4; m++) begin
                j = $urandom_range(0, NREG - 1);
                a = ($urandom_range(0, 9) < 7) ? (cfg_base[j] | (AW'($urandom) & ~cfg_mask[j]))
                                               : AW'($urandom);
                rw   = 1'($urandom_range(0, 1));
                ridx = model_region(a, rw);
                rk   = resp_edge(ridx);
                if ($urandom_range(0, 3) == 0) rel = $urandom_range(2, rk);
                else                           rel = rk + 1 + $urandom_range(0, 3);
                run_access(a, rw, rel, ($urandom_range(0, 3) == 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
